triangle_classifier: RTL
========================

Name: triangle_classifier

Overview:
- Pipelined, parametrised successor to the combinational triangle checker.
- Accepts a stream of side triples (A, B, C) of WIDTH bits over a valid/ready handshake.
- For each triple, reports whether it is a strict triangle, its shape class, and a right-angle flag.
- Keeps saturating statistics counters; sits between a stimulus/register source and a result sink in the seminar datapath.

Parameters:
- WIDTH, 8, bit width of each side.
- CNT_W, 16, width of each statistics counter.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- CLR  input  1  synchronous clear of statistics counters only; pipeline is unaffected.
- IN_VALID  input  1  triple on A/B/C is valid.
- IN_READY  output  1  block accepts a triple this cycle.
- A, B, C  input  WIDTH each  side lengths, unsigned.
- OUT_VALID  output  1  result registers hold a valid result.
- OUT_READY  input  1  sink accepts the result this cycle.
- OUT  output  1  1 = strict triangle.
- SHAPE  output  2  0 = not triangle, 1 = equilateral, 2 = isosceles (non-equilateral), 3 = scalene.
- RIGHT  output  1  1 = right triangle (a²+b²=c², sorted sides); forced 0 when OUT=0.
- TRI_CNT  output  CNT_W  number of delivered results with OUT=1.
- BAD_CNT  output  CNT_W  number of delivered results with OUT=0.

Behaviour:
- Handshakes:
  - Input handshake = IN_VALID && IN_READY; output handshake = OUT_VALID && OUT_READY.
  - Global advance enable EN = !OUT_VALID || OUT_READY; IN_READY = EN (combinational).
  - When EN=0, every pipeline stage, including its valid bit, holds its value.
- Stage 1 (S1): register sides sorted ascending as s0 <= s1 <= s2; register valid bit v1 = IN_VALID.
- Stage 2 (S2):
  - sum = s0+s1 at WIDTH+1 bits (no overflow).
  - sq0+sq1 at 2*WIDTH+1 bits; sq2 at 2*WIDTH bits.
  - Equality flags e01 = (s0==s1), e12 = (s1==s2); zero flag z = (s0==0).
  - Register all of these plus v2.
- Stage 3 (S3 / output):
  - OUT = !z && (sum > s2), strict, so degenerate triples are not triangles.
  - SHAPE = 0 if !OUT; else 1 if e01&&e12; else 2 if e01||e12; else 3.
  - RIGHT = OUT && (sq0+sq1 == sq2).
  - OUT_VALID = v2 advanced.
- Latency: exactly 3 cycles from input handshake to OUT_VALID with no back-pressure. Throughput is 1 triple/cycle while OUT_READY=1.
- Output stability: OUT/SHAPE/RIGHT are stable while OUT_VALID=1 and OUT_READY=0. No result is dropped or duplicated.
- Bubbles: invalid slots propagate as bubbles; data registers of bubble stages are don't-care, but OUT/SHAPE/RIGHT must read 0 when OUT_VALID=0.
- Counters:
  - Each output handshake increments TRI_CNT if OUT=1, else BAD_CNT.
  - Both counters saturate at all-ones and never wrap.
  - CLR clears both to 0; CLR has priority over a simultaneous increment.
- Reset: all valid bits, OUT, SHAPE, RIGHT, TRI_CNT and BAD_CNT are 0. IN_READY is 1 after reset. Reset mid-stream discards all in-flight triples without counting them.

Test Plan:
- Reset, then drive triple 3,4,5 with OUT_READY=1 -> 3 cycles later OUT=1, SHAPE=3, RIGHT=1; TRI_CNT=1.
- Stream back-to-back 1,1,1 / 2,4,6 / 0,128,127 / 255,128,128 / 1,1,50 -> results in order:
  - (1,1,0)
  - (0,0,0)
  - (0,0,0)
  - (1,2,0)
  - (0,0,0)
  - then TRI_CNT=2, BAD_CNT=3.
- Permutation check: 5,3,4 and 4,5,3 give the same result as 3,4,5; WIDTH=8 case 255,255,255 gives OUT=1, SHAPE=1 with no sum overflow.
- Back-pressure: hold OUT_READY=0 for 5 cycles while IN_VALID=1 with 10,100,255 first -> IN_READY=0 once the pipe is full, output held constant (OUT=0). On release, all accepted triples emerge once, in order.
- Counter saturation: instance with CNT_W=2, feed 5 valid triangles -> TRI_CNT sticks at 3. Assert CLR on the same cycle as a handshake -> TRI_CNT=0.
- RST asserted with 2 triples in flight -> next cycle OUT_VALID=0, counters 0; no stale result appears afterwards.

Source files
------------

// File: rtl/triangle_classifier_if.sv
// Stream interface for triangle_classifier: side triples in, classification results and statistics out.
interface triangle_classifier_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             CLR;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT;
  logic [1:0]       SHAPE;
  logic             RIGHT;
  logic [CNT_W-1:0] TRI_CNT;
  logic [CNT_W-1:0] BAD_CNT;

  modport master (
    output CLR, IN_VALID, A, B, C, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, SHAPE, RIGHT, TRI_CNT, BAD_CNT
  );

  modport slave (
    input  CLR, IN_VALID, A, B, C, OUT_READY,
    output IN_READY, OUT_VALID, OUT, SHAPE, RIGHT, TRI_CNT, BAD_CNT
  );
endinterface

// File: rtl/triangle_classifier.sv
// Three-stage triangle classifier: sort sides, form sums/squares/equalities, decide class.
// One global advance enable stalls the whole pipe when the result sink is not ready.
module triangle_classifier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  CLK,
  input logic                  RST,
  triangle_classifier_if.slave bus
);
  localparam int SQ_W = 2 * WIDTH;

  logic             w_en;
  logic [WIDTH-1:0] w_lo_ab;
  logic [WIDTH-1:0] w_hi_ab;
  logic [WIDTH-1:0] w_s0;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;
  logic             w_is_tri;
  logic             w_is_right;
  logic [1:0]       w_shape;

  logic             r_vld_p0;
  logic             r_vld_p1;
  logic             r_vld_p2;
  logic [WIDTH-1:0] r_s0_p0;
  logic [WIDTH-1:0] r_s1_p0;
  logic [WIDTH-1:0] r_s2_p0;
  logic [WIDTH:0]   r_sum_p1;
  logic [SQ_W:0]    r_sq01_p1;
  logic [SQ_W-1:0]  r_sq2_p1;
  logic [WIDTH-1:0] r_s2_p1;
  logic             r_e01_p1;
  logic             r_e12_p1;
  logic             r_z_p1;
  logic             r_out_p2;
  logic [1:0]       r_shape_p2;
  logic             r_right_p2;
  logic [CNT_W-1:0] r_tri_cnt;
  logic [CNT_W-1:0] r_bad_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SQ_W-1:0] square(input logic [WIDTH-1:0] v);
    return SQ_W'(v) * SQ_W'(v);
  endfunction

  assign w_en = !r_vld_p2 || bus.OUT_READY;

  // Input -> p0: sort the three sides ascending
  always_comb begin
    w_lo_ab = (bus.A < bus.B) ? bus.A : bus.B;
    w_hi_ab = (bus.A < bus.B) ? bus.B : bus.A;
    w_s0    = (bus.C < w_lo_ab) ? bus.C : w_lo_ab;
    w_s2    = (bus.C > w_hi_ab) ? bus.C : w_hi_ab;
    if (bus.C < w_lo_ab) begin
      w_s1 = w_lo_ab;
    end else if (bus.C > w_hi_ab) begin
      w_s1 = w_hi_ab;
    end else begin
      w_s1 = bus.C;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_en) begin
      r_s0_p0   <= w_s0;
      r_s1_p0   <= w_s1;
      r_s2_p0   <= w_s2;
      // p0 -> p1: widened sums and squares, equality and zero flags
      r_sum_p1  <= (WIDTH+1)'(r_s0_p0) + (WIDTH+1)'(r_s1_p0);
      r_sq01_p1 <= (SQ_W+1)'(square(r_s0_p0)) + (SQ_W+1)'(square(r_s1_p0));
      r_sq2_p1  <= square(r_s2_p0);
      r_s2_p1   <= r_s2_p0;
      r_e01_p1  <= (r_s0_p0 == r_s1_p0);
      r_e12_p1  <= (r_s1_p0 == r_s2_p0);
      r_z_p1    <= (r_s0_p0 == '0);
    end
  end

  // p1 -> p2: strict triangle test and shape decision
  assign w_is_tri   = !r_z_p1 && (r_sum_p1 > {1'b0, r_s2_p1});
  assign w_is_right = w_is_tri && (r_sq01_p1 == {1'b0, r_sq2_p1});

  always_comb begin
    w_shape = 2'd0;
    if (w_is_tri) begin
      if (r_e01_p1 && r_e12_p1) begin
        w_shape = 2'd1;
      end else if (r_e01_p1 || r_e12_p1) begin
        w_shape = 2'd2;
      end else begin
        w_shape = 2'd3;
      end
    end
  end

  // Bubbles load zeros so the result fields read 0 whenever OUT_VALID is low
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_out_p2   <= 1'b0;
      r_shape_p2 <= 2'd0;
      r_right_p2 <= 1'b0;
    end else if (w_en) begin
      r_vld_p0   <= bus.IN_VALID;
      r_vld_p1   <= r_vld_p0;
      r_vld_p2   <= r_vld_p1;
      r_out_p2   <= r_vld_p1 && w_is_tri;
      r_shape_p2 <= r_vld_p1 ? w_shape : 2'd0;
      r_right_p2 <= r_vld_p1 && w_is_right;
    end
  end

  // Statistics: clear wins over a coincident delivery
  always_ff @(posedge CLK) begin
    if (RST || bus.CLR) begin
      r_tri_cnt <= '0;
      r_bad_cnt <= '0;
    end else if (r_vld_p2 && bus.OUT_READY) begin
      if (r_out_p2) begin
        r_tri_cnt <= sat_inc(r_tri_cnt);
      end else begin
        r_bad_cnt <= sat_inc(r_bad_cnt);
      end
    end
  end

  assign bus.IN_READY  = w_en;
  assign bus.OUT_VALID = r_vld_p2;
  assign bus.OUT       = r_out_p2;
  assign bus.SHAPE     = r_shape_p2;
  assign bus.RIGHT     = r_right_p2;
  assign bus.TRI_CNT   = r_tri_cnt;
  assign bus.BAD_CNT   = r_bad_cnt;
endmodule
